i2c_cmd_queue: RTL and testbench

//  Board-input front end for the I2C master. Debounces the user keys and loads register and data

---
 rtl/i2c_cmd_queue_if.sv | 32 +++
 rtl/i2c_cmd_queue.sv | 123 ++++++++++++
 tb/tb_i2c_cmd_queue.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_cmd_queue_if : command handshake between the key/switch queue and the
//                    I2C master (valid/ready plus {rw, reg, data} payload).
// Revision: 1.0
// ---------------------------------------------------------------------------
interface i2c_cmd_queue_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [DATA_W-1:0] cmd_reg;
  logic [DATA_W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_rw,
    output cmd_reg,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_rw,
    input  cmd_reg,
    input  cmd_data,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/i2c_cmd_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_cmd_queue : debounced board keys stage reg/data from the switches and
//                 push {rw, reg, data} commands into a FIFO for the I2C master.
// Revision: 1.0
// ---------------------------------------------------------------------------
module i2c_cmd_queue #(
  parameter int DATA_W          = 8,
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic [DATA_W:0]              sw,
  input  wire logic [2:0]                   keys_n,
  i2c_cmd_queue_if.master                   cmd,
  output logic      [$clog2(DEPTH+1)-1:0]   level,
  output logic                              full,
  output logic                              overflow
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = $clog2(DEPTH+1);
  localparam int c_ENT_W = 2*DATA_W + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(DEPTH);

  // w_press[0]=push, [1]=load data, [2]=load reg
  logic [2:0] w_press;

  for (genvar k = 0; k < 3; k++) begin : g_key
    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_stable_d;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    // Idle level of every stage is "released" so a key held through reset
    // is debounced afresh and reported once afterwards.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync1    <= 1'b1;
        r_sync2    <= 1'b1;
        r_stable   <= 1'b1;
        r_stable_d <= 1'b1;
        r_press    <= 1'b0;
        r_cnt      <= '0;
      end else begin
        r_sync1    <= keys_n[k];
        r_sync2    <= r_sync1;
        r_stable_d <= r_stable;
        r_press    <= r_stable_d & ~r_stable;
        if (r_sync2 == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end
    end

    assign w_press[k] = r_press;
  end

  logic [DATA_W-1:0]  r_stage_reg;
  logic [DATA_W-1:0]  r_stage_data;
  logic [c_ENT_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0] r_level;
  logic               r_overflow;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_wr_en;

  assign w_valid = (r_level != '0);
  assign w_full  = (r_level == c_LVL_FULL);
  assign w_pop   = w_valid & cmd.cmd_ready;
  // A pop in the same cycle frees the slot the push needs, so full only blocks a lone push.
  assign w_wr_en = w_press[0] & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage_reg  <= '0;
      r_stage_data <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_press[1]) r_stage_data <= sw[DATA_W:1];
      if (w_press[2]) r_stage_reg  <= sw[DATA_W:1];
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= {sw[0], r_stage_reg, r_stage_data};
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_press[0] & w_full & ~w_pop) r_overflow <= 1'b1;
    end
  end

  assign cmd.cmd_valid = w_valid;
  assign {cmd.cmd_rw, cmd.cmd_reg, cmd.cmd_data} = r_mem[r_rd_ptr];
  assign level    = r_level;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_i2c_cmd_queue : directed key/switch stimulus with a scoreboard of queued
//                    commands checked by an independent output monitor.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_i2c_cmd_queue;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int DEB    = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W:0]   sw = '0;
  logic [2:0]        keys_n = 3'b111;
  logic [2:0]        level;
  logic              full;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] sb [$];

  i2c_cmd_queue_if #(.DATA_W(DATA_W)) cmd_if ();

  i2c_cmd_queue #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .keys_n(keys_n),
    .cmd(cmd_if),
    .level(level),
    .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat, and checks that a
  // stalled head stays put.
  logic [16:0] prev_out = '0;
  logic        prev_hold = 1'b0;
  always @(negedge clk) begin
    logic [16:0] out;
    logic [16:0] exp;
    out = {cmd_if.cmd_rw, cmd_if.cmd_reg, cmd_if.cmd_data};
    if (!reset && cmd_if.cmd_valid) begin
      if (prev_hold) chk("hold_stable", 32'(out), 32'(prev_out));
      if (cmd_if.cmd_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got %h, expected no command", out);
        end else begin
          exp = sb.pop_front();
          chk("pop_order", 32'(out), 32'(exp));
        end
      end
    end
    prev_hold <= !reset && cmd_if.cmd_valid && !cmd_if.cmd_ready;
    prev_out  <= out;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input int k);
    keys_n[k] = 1'b0;
    repeat (6) tick();
    keys_n[k] = 1'b1;
    repeat (8) tick();
  endtask

  task automatic push_cmd(input logic rw, input logic [7:0] r, input logic [7:0] d,
                          input bit accept);
    sw = {r, 1'b0};
    press(2);
    sw = {d, 1'b1};
    press(1);
    sw = {8'hFF, rw};
    if (accept) sb.push_back({rw, r, d});
    press(0);
  endtask

  task automatic drain();
    cmd_if.cmd_ready = 1'b1;
    for (int i = 0; i < 40 && (sb.size() != 0 || level != 0); i++) tick();
    tick();
    cmd_if.cmd_ready = 1'b0;
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_valid", 32'(cmd_if.cmd_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    cmd_if.cmd_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk("rst_payload", 32'({cmd_if.cmd_rw, cmd_if.cmd_reg, cmd_if.cmd_data}), 32'd0);

    // T1: reg 0xAA from sw=0x154, data 0x55, then a push with exact latency check
    sw = 9'h154;
    keys_n[2] = 1'b0;
    repeat (10) tick();
    keys_n[2] = 1'b1;
    repeat (8) tick();
    sw = {8'h55, 1'b0};
    press(1);
    sw = {8'hFF, 1'b0};
    sb.push_back({1'b0, 8'hAA, 8'h55});
    keys_n[0] = 1'b0;
    repeat (7) tick();
    chk("t1_level_cycle6", 32'(level), 32'd0);
    tick();
    chk("t1_level_cycle7", 32'(level), 32'd1);
    chk("t1_valid_cycle7", 32'(cmd_if.cmd_valid), 32'd1);
    repeat (2) tick();
    keys_n[0] = 1'b1;
    repeat (8) tick();
    chk("t1_level_once", 32'(level), 32'd1);
    drain();

    // T2: 2-cycle glitch is filtered
    keys_n[0] = 1'b0;
    repeat (2) tick();
    keys_n[0] = 1'b1;
    repeat (12) tick();
    chk("t2_level", 32'(level), 32'd0);

    // T3: stalled head is presented and held
    push_cmd(1'b1, 8'h12, 8'h34, 1'b1);
    chk("t3_valid", 32'(cmd_if.cmd_valid), 32'd1);
    chk("t3_payload", 32'({cmd_if.cmd_rw, cmd_if.cmd_reg, cmd_if.cmd_data}), 32'h11234);
    repeat (20) tick();
    chk("t3_payload_held", 32'({cmd_if.cmd_rw, cmd_if.cmd_reg, cmd_if.cmd_data}), 32'h11234);
    drain();

    // T4: five pushes into a four-deep queue
    for (int i = 0; i < 4; i++) push_cmd(i[0], 8'h20 + 8'(i), 8'h40 + 8'(i), 1'b1);
    chk("t4_full_before", 32'(full), 32'd1);
    chk("t4_ovf_before", 32'(overflow), 32'd0);
    push_cmd(1'b1, 8'h2F, 8'h4F, 1'b0);
    chk("t4_level", 32'(level), 32'd4);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_overflow", 32'(overflow), 32'd1);
    drain();
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);

    // T5: push and pop together while full
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 8'h60 + 8'(i), 8'h80 + 8'(i), 1'b1);
    sw = {8'h77, 1'b0};
    press(2);
    sw = {8'h99, 1'b0};
    press(1);
    sw = {8'hFF, 1'b1};
    keys_n[0] = 1'b0;
    repeat (7) tick();
    cmd_if.cmd_ready = 1'b1;
    sb.push_back({1'b1, 8'h77, 8'h99});
    tick();
    cmd_if.cmd_ready = 1'b0;
    chk("t5_level", 32'(level), 32'd4);
    chk("t5_full", 32'(full), 32'd1);
    chk("t5_overflow", 32'(overflow), 32'd0);
    keys_n[0] = 1'b1;
    repeat (8) tick();
    drain();

    // T6: reset with a full queue and a key mid-debounce
    for (int i = 0; i < 5; i++) push_cmd(1'b1, 8'hA0 + 8'(i), 8'hB0 + 8'(i), 1'b0);
    chk("t6_level_pre", 32'(level), 32'd4);
    chk("t6_ovf_pre", 32'(overflow), 32'd1);
    keys_n[0] = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    keys_n[0] = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (15) tick();
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_full", 32'(full), 32'd0);

    // T7: push key held through reset gives one command after debounce
    reset = 1'b1;
    sw = {8'hFF, 1'b1};
    keys_n[0] = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    sb.push_back({1'b1, 8'h00, 8'h00});
    repeat (7) tick();
    chk("t7_level_cycle6", 32'(level), 32'd0);
    tick();
    chk("t7_level_cycle7", 32'(level), 32'd1);
    repeat (4) tick();
    keys_n[0] = 1'b1;
    repeat (8) tick();
    chk("t7_level_once", 32'(level), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
